// File: rtl/barrel_rshift_4.sv
// Registered 4-bit logical right barrel shifter (zero fill), two log stages then one register.
// Latency 1 cycle, one result per cycle; no enable or backpressure, every edge captures new input.
module barrel_rshift_4 (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] data,
   input  logic [1:0] sel,
   output logic [3:0] out
);

   logic [3:0] stage_a;
   logic [3:0] stage_b;

   // Stage A: shift by one when sel[0] is set; constant zero enters at the MSB.
   always_comb begin
      stage_a[3] = sel[0] ? 1'b0    : data[3];
      stage_a[2] = sel[0] ? data[3] : data[2];
      stage_a[1] = sel[0] ? data[2] : data[1];
      stage_a[0] = sel[0] ? data[1] : data[0];
   end

   // Stage B: shift the stage A result by two when sel[1] is set.
   always_comb begin
      stage_b[3] = sel[1] ? 1'b0       : stage_a[3];
      stage_b[2] = sel[1] ? 1'b0       : stage_a[2];
      stage_b[1] = sel[1] ? stage_a[3] : stage_a[1];
      stage_b[0] = sel[1] ? stage_a[2] : stage_a[0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out <= 4'b0000;
      end else begin
         out <= stage_b;
      end
   end

endmodule

// File: tb/tb_barrel_rshift_4.sv
// Scoreboard bench for barrel_rshift_4: each drive pushes the expected result,
// which is popped and compared one edge later.
module tb_barrel_rshift_4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] data = 4'b1111;
   logic [1:0] sel = 2'b00;
   logic [3:0] out;

   logic [3:0] exp_q[$];
   int         errors = 0;
   int         checks = 0;

   barrel_rshift_4 dut (
      .clk  (clk),
      .rst  (rst),
      .data (data),
      .sel  (sel),
      .out  (out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: out=%b expected=%b", tag, got, want);
      end
   endtask

   // Drive on the falling edge, then compare the popped expectation just after the rising edge.
   task automatic drive(input logic [3:0] d, input logic [1:0] s, input logic r,
                        input logic [3:0] e, input string tag);
      @(negedge clk);
      data = d;
      sel  = s;
      rst  = r;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      chk(tag, out, exp_q.pop_front());
   endtask

   function automatic logic [3:0] model(input logic [3:0] d, input logic [1:0] s);
      logic [3:0] v;
      v = d;
      for (int k = 0; k < 3; k++) begin
         if (k < int'(s)) v = {1'b0, v[3:1]};
      end
      return v;
   endfunction

   initial begin
      // Reset with a non-zero operand presented.
      drive(4'b1111, 2'd0, 1'b1, 4'b0000, "reset");

      // Directed cases with hand-derived results.
      drive(4'b1000, 2'b01, 1'b0, 4'b0100, "shr1");
      drive(4'b1000, 2'b10, 1'b0, 4'b0010, "shr2");
      drive(4'b1000, 2'b11, 1'b0, 4'b0001, "shr3");
      drive(4'b1011, 2'd0,  1'b0, 4'b1011, "shr0");
      drive(4'b1011, 2'd3,  1'b0, 4'b0001, "fill_1011");
      drive(4'b0111, 2'd3,  1'b0, 4'b0000, "no_rotate");
      drive(4'b1111, 2'd1,  1'b0, 4'b0111, "no_sign_fill");
      drive(4'b0110, 2'd2,  1'b0, 4'b0001, "shr2_0110");

      // Exhaustive back-to-back stream.
      for (int d = 0; d < 16; d++) begin
         for (int s = 0; s < 4; s++) begin
            drive(4'(d), 2'(s), 1'b0, model(4'(d), 2'(s)), "exhaustive");
         end
      end

      // Same stream with a one-edge reset inserted mid-stream.
      for (int i = 0; i < 64; i++) begin
         if (i == 29) begin
            drive(4'(i[5:2]), 2'(i[1:0]), 1'b1, 4'b0000, "mid_reset");
         end else if (i == 30) begin
            drive(4'(i[5:2]), 2'(i[1:0]), 1'b0, model(4'(i[5:2]), 2'(i[1:0])), "after_reset");
         end else begin
            drive(4'(i[5:2]), 2'(i[1:0]), 1'b0, model(4'(i[5:2]), 2'(i[1:0])), "stream");
         end
      end

      // Random pattern including occasional reset edges.
      for (int i = 0; i < 40; i++) begin
         logic [3:0] d;
         logic [1:0] s;
         logic       r;
         d = 4'($urandom_range(15, 0));
         s = 2'($urandom_range(3, 0));
         r = ($urandom_range(9, 0) == 0);
         drive(d, s, r, r ? 4'b0000 : model(d, s), "random");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
